pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. It merges per-stage stall requests into the pipeline-wide stall vector consumed by pc_reg and every stage register, including the MEM/WB register. It also converts a committed exception or ERET from the MEM stage into a registered one-cycle flush pulse with a redirect PC. Optionally, it runs a stall watchdog that flags stalls lasting too long.

---
 rtl/pipe_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline stall merge, exception flush/redirect, optional stall watchdog.
// Watchdog is built only when STALL_WDT_EN is defined.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter int          STALL_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        exc_valid,
  input  logic [31:0] exc_type,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
);

  localparam logic [31:0] ERET = 32'h0000_000e;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        flush_nxt;
  logic [31:0] pc_nxt;
  logic [5:0]  req_stall;

  always_comb begin
    req_stall = 6'b000000;
    if (stallreq_mem)
      req_stall = 6'b011111;
    else if (stallreq_ex)
      req_stall = 6'b001111;
    else if (stallreq_id)
      req_stall = 6'b000111;
    else if (stallreq_if)
      req_stall = 6'b000011;
  end

  always_comb begin
    state_nxt = state;
    flush_nxt = 1'b0;
    pc_nxt    = 32'h0;
    stall     = 6'b000000;
    unique case (state)
      RUN: begin
        if (exc_valid) begin
          state_nxt = FLUSH;
          flush_nxt = 1'b1;
          pc_nxt    = (exc_type == ERET) ? cp0_epc : EXC_VECTOR;
        end else begin
          stall = req_stall;
        end
      end
      FLUSH: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    // Requests are ignored while reset is held.
    if (!rst)
      stall = 6'b000000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      flush  <= 1'b0;
      new_pc <= 32'h0;
    end else begin
      state  <= state_nxt;
      flush  <= flush_nxt;
      new_pc <= pc_nxt;
    end
  end

`ifdef STALL_WDT_EN
  localparam logic [15:0] LIM    = 16'(STALL_LIMIT);
  localparam logic [15:0] LIM_M1 = 16'(STALL_LIMIT - 1);

  logic [15:0] wdt_cnt;
  logic        wdt_flag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_cnt  <= 16'h0;
      wdt_flag <= 1'b0;
    end else begin
      if (stall == 6'b000000)
        wdt_cnt <= 16'h0;
      else if (wdt_cnt != LIM)
        wdt_cnt <= wdt_cnt + 16'h1;
      if (stall != 6'b000000 && wdt_cnt == LIM_M1)
        wdt_flag <= 1'b1;
    end
  end

  assign stall_timeout = wdt_flag;
`else
  logic unused_lim;
  assign unused_lim    = ^STALL_LIMIT;
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl against a cycle-level reference model.
// Watchdog expectations follow STALL_WDT_EN.
module tb_pipe_ctrl;

`ifdef STALL_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif
  localparam int LIMIT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rq_if = 1'b0;
  logic        rq_id = 1'b0;
  logic        rq_ex = 1'b0;
  logic        rq_mem = 1'b0;
  logic        exc_valid = 1'b0;
  logic [31:0] exc_type = 32'h0;
  logic [31:0] cp0_epc = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;

  int checks = 0;
  int errors = 0;

  bit          m_flush;
  logic [31:0] m_pc;
  int          m_run;
  bit          m_to;
  int          pulses;

  pipe_ctrl #(.EXC_VECTOR(32'h20), .STALL_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .stallreq_if(rq_if),
    .stallreq_id(rq_id),
    .stallreq_ex(rq_ex),
    .stallreq_mem(rq_mem),
    .exc_valid(exc_valid),
    .exc_type(exc_type),
    .cp0_epc(cp0_epc),
    .stall(stall),
    .flush(flush),
    .new_pc(new_pc),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  // Stall mask is a run of ones: 2 bits for IF up to 5 bits for MEM.
  function automatic logic [5:0] exp_stall();
    int n;
    if (!rst || m_flush || exc_valid) return 6'd0;
    n = rq_mem ? 5 : rq_ex ? 4 : rq_id ? 3 : rq_if ? 2 : 0;
    return 6'((1 << n) - 1);
  endfunction

  task automatic model_reset();
    m_flush = 0;
    m_pc    = 32'h0;
    m_run   = 0;
    m_to    = 0;
  endtask

  task automatic tick();
    logic [5:0] s;
    @(posedge clk);
    if (rst) begin
      s = exp_stall();
      if (s == 0) m_run = 0;
      else if (m_run < LIMIT) m_run++;
      if (WDT && m_run == LIMIT) m_to = 1;
      if (!m_flush && exc_valid) begin
        m_pc    = (exc_type == 32'he) ? cp0_epc : 32'h20;
        m_flush = 1;
      end else begin
        m_pc    = 32'h0;
        m_flush = 0;
      end
    end
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    {rq_mem, rq_ex, rq_id, rq_if} = r;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_req(4'b0);
    exc_valid = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    set_req(4'b1111);
    exc_valid = 1'b0;
    #2;
    checks += 3;
    if (stall !== 6'd0) begin
      errors++; $display("FAIL rst_stall got %b want 000000", stall);
    end
    if (flush !== 1'b0) begin
      errors++; $display("FAIL rst_flush got %b want 0", flush);
    end
    if (new_pc !== 32'h0) begin
      errors++; $display("FAIL rst_pc got %h want 0", new_pc);
    end
    tick();
    checks += 2;
    if (stall !== 6'd0) begin
      errors++; $display("FAIL rst_hold_stall got %b want 0", stall);
    end
    if (stall_timeout !== 1'b0) begin
      errors++; $display("FAIL rst_timeout got %b want 0", stall_timeout);
    end
    @(negedge clk);
    rst = 1'b1;
    set_req(4'b0110);
    #1;
    checks++;
    if (stall !== 6'b001111 || stall !== exp_stall()) begin
      errors++; $display("FAIL prio_ex got %b want 001111", stall);
    end
    rq_mem = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b011111) begin
      errors++; $display("FAIL prio_mem got %b want 011111", stall);
    end
  endtask

  task automatic test_exception();
    hard_reset();
    set_req(4'b1000);
    exc_valid = 1'b1;
    exc_type  = 32'h1;
    #1;
    checks++;
    if (stall !== 6'd0) begin
      errors++; $display("FAIL exc_stall got %b want 0", stall);
    end
    tick();
    exc_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (flush !== 1'b1 || flush !== m_flush) begin
      errors++; $display("FAIL exc_flush got %b want 1", flush);
    end
    if (new_pc !== 32'h20 || new_pc !== m_pc) begin
      errors++; $display("FAIL exc_pc got %h want 20", new_pc);
    end
    checks++;
    if (stall !== 6'd0) begin
      errors++; $display("FAIL exc_flush_stall got %b want 0", stall);
    end
    tick();
    @(negedge clk);
    checks += 3;
    if (flush !== 1'b0) begin
      errors++; $display("FAIL exc_end got %b want 0", flush);
    end
    if (new_pc !== 32'h0) begin
      errors++; $display("FAIL exc_end_pc got %h want 0", new_pc);
    end
    if (stall !== 6'b011111) begin
      errors++; $display("FAIL exc_resume got %b want 011111", stall);
    end
  endtask

  task automatic test_eret();
    hard_reset();
    exc_valid = 1'b1;
    exc_type  = 32'he;
    cp0_epc   = 32'h8000_0100;
    tick();
    exc_valid = 1'b0;
    cp0_epc   = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h8000_0100) begin
      errors++;
      $display("FAIL eret got f=%b pc=%h want f=1 pc=80000100", flush, new_pc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit want [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    hard_reset();
    pulses    = 0;
    exc_valid = 1'b1;
    exc_type  = 32'h4;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 2) exc_valid = 1'b0;
      @(negedge clk);
      if (flush) pulses++;
      checks++;
      if (flush !== want[i] || flush !== m_flush) begin
        errors++;
        $display("FAIL b2b_cyc%0d got %b want %b", i, flush, want[i]);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL b2b_pulses got %0d want 2", pulses);
    end
  endtask

  task automatic test_watchdog();
    hard_reset();
    rq_if = 1'b1;
    for (int i = 0; i < LIMIT - 1; i++) tick();
    @(negedge clk);
    checks++;
    if (stall_timeout !== 1'b0) begin
      errors++; $display("FAIL wdt_15 got %b want 0", stall_timeout);
    end
    tick();
    @(negedge clk);
    checks++;
    if (stall_timeout !== WDT || stall_timeout !== m_to) begin
      errors++; $display("FAIL wdt_16 got %b want %b", stall_timeout, WDT);
    end
    rq_if = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (stall_timeout !== WDT) begin
      errors++; $display("FAIL wdt_sticky got %b want %b", stall_timeout, WDT);
    end
  endtask

  task automatic test_async_reset();
    hard_reset();
    exc_valid = 1'b1;
    exc_type  = 32'h2;
    tick();
    exc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (flush !== 1'b1) begin
      errors++; $display("FAIL arst_pre got %b want 1", flush);
    end
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (flush !== 1'b0 || new_pc !== 32'h0) begin
      errors++;
      $display("FAIL arst_clear got f=%b pc=%h want 0/0", flush, new_pc);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    hard_reset();
    for (int i = 0; i < 400; i++) begin
      tick();
      set_req(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      exc_valid = ($urandom_range(0, 9) == 0);
      exc_type  = ($urandom_range(0, 1) == 0) ? 32'he : $urandom;
      cp0_epc   = $urandom;
      if (i % 50 == 10) set_req(4'b0001);
      @(negedge clk);
      checks++;
      if (stall !== exp_stall() || flush !== m_flush ||
          new_pc !== m_pc || stall_timeout !== m_to) begin
        errors++;
        $display("FAIL rand_%0d got s=%b f=%b pc=%h t=%b want s=%b f=%b pc=%h t=%b",
                 i, stall, flush, new_pc, stall_timeout,
                 exp_stall(), m_flush, m_pc, m_to);
      end
    end
  endtask

  task automatic test_wdt_random();
    hard_reset();
    for (int i = 0; i < 120; i++) begin
      tick();
      set_req((i % 40 < 30) ? 4'b0010 : 4'b0000);
      exc_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (stall_timeout !== m_to || stall !== exp_stall()) begin
        errors++;
        $display("FAIL wdtr_%0d got t=%b s=%b want t=%b s=%b",
                 i, stall_timeout, stall, m_to, exp_stall());
      end
    end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_eret();
    test_back_to_back();
    test_watchdog();
    test_async_reset();
    test_wdt_random();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
